// File: rtl/bp_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_update_scheduler                                                        |
// | Branch predictor table write-port owner: redirect, update FIFO, clear sweep|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bp_update_scheduler #(
  parameter int INDEX_BITS = 5,
  parameter int HIST_BITS  = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_valid,
  input  logic [31:0]           res_pc,
  input  logic [31:0]           res_actual_pc,
  input  logic [31:0]           res_predicted_pc,
  input  logic                  res_taken,
  output logic                  res_ready,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  clear_req,
  input  logic                  tbl_ready,
  output logic                  tbl_we,
  output logic                  tbl_clear,
  output logic [INDEX_BITS-1:0] tbl_index,
  output logic [24:0]           tbl_tag,
  output logic [31:0]           tbl_target,
  output logic                  tbl_taken,
  output logic [HIST_BITS-1:0]  ghr,
  output logic                  init_done,
  output logic [7:0]            drop_count
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int PTR_BITS  = ADDR_BITS + 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [INDEX_BITS-1:0] r_sweep;
  logic [HIST_BITS-1:0]  r_ghr;
  logic [7:0]            r_drop_count;
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;

  logic [INDEX_BITS-1:0] r_mem_index  [DEPTH];
  logic [24:0]           r_mem_tag    [DEPTH];
  logic [31:0]           r_mem_target [DEPTH];
  logic                  r_mem_taken  [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_enter_init;
  logic w_unused;

  assign w_unused = &{1'b0, res_pc[1:0]};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_BITS-1] != r_rd_ptr[PTR_BITS-1]) &&
                   (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);

  // Full is judged on registered pointers, so a same-cycle pop never frees a slot for a push.
  assign w_push       = res_valid && !w_full && (r_state != ST_DRAIN);
  assign w_pop        = (r_state != ST_INIT) && !w_empty && tbl_ready;
  assign w_enter_init = (r_state == ST_DRAIN) && w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (tbl_ready && (r_sweep == '1)) w_state_nxt = ST_RUN;
      ST_RUN:   if (clear_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_INIT;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    tbl_we     = 1'b0;
    tbl_clear  = 1'b0;
    tbl_index  = r_mem_index[r_rd_ptr[ADDR_BITS-1:0]];
    tbl_tag    = r_mem_tag[r_rd_ptr[ADDR_BITS-1:0]];
    tbl_target = r_mem_target[r_rd_ptr[ADDR_BITS-1:0]];
    tbl_taken  = r_mem_taken[r_rd_ptr[ADDR_BITS-1:0]];
    if (r_state == ST_INIT) begin
      tbl_we     = reset;
      tbl_clear  = 1'b1;
      tbl_index  = r_sweep;
      tbl_tag    = '0;
      tbl_target = '0;
      tbl_taken  = 1'b0;
    end else begin
      tbl_we = reset && !w_empty;
    end
  end

  assign res_ready      = !w_full;
  assign redirect_valid = res_valid && (res_actual_pc != res_predicted_pc);
  assign redirect_pc    = res_actual_pc;
  assign ghr            = r_ghr;
  assign init_done      = (r_state == ST_RUN);
  assign drop_count     = r_drop_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_sweep      <= '0;
      r_ghr        <= '0;
      r_drop_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter_init) r_sweep <= '0;
      else if ((r_state == ST_INIT) && tbl_ready) r_sweep <= r_sweep + INDEX_BITS'(1);
      if (w_enter_init) r_ghr <= '0;
      else if (res_valid) r_ghr <= {r_ghr[HIST_BITS-2:0], res_taken};
      if (res_valid && w_full && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
    end
  end

  // Index is hashed with the history value before this branch shifts in.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_index[r_wr_ptr[ADDR_BITS-1:0]]  <= res_pc[INDEX_BITS+1:2] ^ r_ghr;
      r_mem_tag[r_wr_ptr[ADDR_BITS-1:0]]    <= res_pc[31:7];
      r_mem_target[r_wr_ptr[ADDR_BITS-1:0]] <= res_actual_pc;
      r_mem_taken[r_wr_ptr[ADDR_BITS-1:0]]  <= res_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bp_update_scheduler                                                     |
// | Self-checking bench with a queue-based reference model                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] res_actual_pc;
  logic [31:0] res_predicted_pc;
  logic        res_taken;
  logic        res_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        clear_req;
  logic        tbl_ready;
  logic        tbl_we;
  logic        tbl_clear;
  logic [4:0]  tbl_index;
  logic [24:0] tbl_tag;
  logic [31:0] tbl_target;
  logic        tbl_taken;
  logic [4:0]  ghr;
  logic        init_done;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_update_scheduler #(.INDEX_BITS(5), .HIST_BITS(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_pc(res_pc), .res_actual_pc(res_actual_pc),
    .res_predicted_pc(res_predicted_pc), .res_taken(res_taken), .res_ready(res_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .clear_req(clear_req), .tbl_ready(tbl_ready),
    .tbl_we(tbl_we), .tbl_clear(tbl_clear), .tbl_index(tbl_index), .tbl_tag(tbl_tag),
    .tbl_target(tbl_target), .tbl_taken(tbl_taken), .ghr(ghr),
    .init_done(init_done), .drop_count(drop_count)
  );

  // Reference model: a record queue plus a phase (0 clearing, 1 running, 2 draining).
  typedef struct {
    logic [4:0]  idx;
    logic [24:0] tag;
    logic [31:0] tgt;
    logic        tk;
  } rec_t;

  rec_t       q[$];
  int         m_phase;
  int         m_sweep;
  logic [4:0] m_ghr;
  int         m_drops;

  function automatic void model_reset();
    q.delete();
    m_phase = 0;
    m_sweep = 0;
    m_ghr   = '0;
    m_drops = 0;
  endfunction

  function automatic void model_step();
    bit   full;
    bit   was_empty;
    int   ph;
    rec_t r;
    if (!reset) begin
      model_reset();
      return;
    end
    full      = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ph        = m_phase;
    if (res_valid && full && m_drops < 255) m_drops++;
    if (ph != 0 && !was_empty && tbl_ready) void'(q.pop_front());
    if (res_valid && !full && ph != 2) begin
      r.idx = res_pc[6:2] ^ m_ghr;
      r.tag = res_pc[31:7];
      r.tgt = res_actual_pc;
      r.tk  = res_taken;
      q.push_back(r);
    end
    if (res_valid) m_ghr = {m_ghr[3:0], res_taken};
    if (ph == 0 && tbl_ready) begin
      if (m_sweep == 31) begin
        m_phase = 1;
        m_sweep = 0;
      end else begin
        m_sweep++;
      end
    end else if (ph == 1 && clear_req) begin
      m_phase = 2;
    end else if (ph == 2 && was_empty) begin
      m_phase = 0;
      m_sweep = 0;
      m_ghr   = '0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    res_valid        = 1'b0;
    res_pc           = '0;
    res_actual_pc    = '0;
    res_predicted_pc = '0;
    res_taken        = 1'b0;
    clear_req        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    tbl_ready = 1'b1;
    reset     = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0 || init_done !== 1'b0 || ghr !== 5'd0 || drop_count !== 8'd0 || res_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: we=%b done=%b ghr=%0h drops=%0d ready=%b required 0 0 0 0 1",
               tbl_we, init_done, ghr, drop_count, res_ready);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (tbl_we !== 1'b1 || tbl_clear !== 1'b1 || tbl_index !== 5'(i) || init_done !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep[%0d]: we=%b clr=%b idx=%0d done=%b required 1 1 %0d 0",
                 i, tbl_we, tbl_clear, tbl_index, init_done, i);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || tbl_we !== 1'b0 || ghr !== 5'd0) begin
      failures++;
      $display("FAIL init_done_rise: done=%b we=%b ghr=%0h required 1 0 0", init_done, tbl_we, ghr);
    end
    tick();
  endtask

  task automatic test_enqueue();
    tbl_ready        = 1'b0;
    res_valid        = 1'b1;
    res_pc           = 32'h0000_0084;
    res_actual_pc    = 32'h0000_0100;
    res_predicted_pc = 32'h0000_0100;
    res_taken        = 1'b1;
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL enq_no_redirect: got %b required 0", redirect_valid);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b1 || tbl_clear !== 1'b0 || tbl_index !== 5'h01 || tbl_tag !== 25'h1) begin
      failures++;
      $display("FAIL enq_head: we=%b clr=%b idx=%0h tag=%0h required 1 0 1 1", tbl_we, tbl_clear, tbl_index, tbl_tag);
    end
    checks++;
    if (tbl_target !== 32'h100 || tbl_taken !== 1'b1 || ghr !== 5'b00001) begin
      failures++;
      $display("FAIL enq_data: tgt=%0h tk=%b ghr=%0h required 100 1 1", tbl_target, tbl_taken, ghr);
    end
    tick();
    tbl_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0) begin
      failures++;
      $display("FAIL enq_popped: we=%b required 0", tbl_we);
    end
    tick();
  endtask

  task automatic test_redirect();
    tbl_ready        = 1'b1;
    res_valid        = 1'b1;
    res_pc           = $urandom;
    res_actual_pc    = 32'h0000_0200;
    res_predicted_pc = 32'h0000_0088;
    res_taken        = 1'($urandom);
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
      failures++;
      $display("FAIL redirect: valid=%b pc=%0h required 1 200", redirect_valid, redirect_pc);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_idle: valid=%b required 0", redirect_valid);
    end
    tick();
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] pcs [6];
    logic [31:0] tgts[6];
    logic        tks [6];
    logic [4:0]  g;
    logic [4:0]  idx;
    g         = m_ghr;
    tbl_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pcs[k]           = $urandom;
      tgts[k]          = $urandom;
      tks[k]           = 1'($urandom);
      res_valid        = 1'b1;
      res_pc           = pcs[k];
      res_actual_pc    = tgts[k];
      res_predicted_pc = (k == 5) ? (tgts[k] ^ 32'h4) : tgts[k];
      res_taken        = tks[k];
      @(negedge clk);
      checks++;
      if (res_ready !== (k < 4)) begin
        failures++;
        $display("FAIL full_ready[%0d]: got %b required %b", k, res_ready, (k < 4));
      end
      if (k == 5) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== tgts[k]) begin
          failures++;
          $display("FAIL full_redirect: valid=%b pc=%0h required 1 %0h", redirect_valid, redirect_pc, tgts[k]);
        end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (drop_count !== 8'd2) begin
      failures++;
      $display("FAIL full_drops: got %0d required 2", drop_count);
    end
    tick();
    tbl_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idx = pcs[k][6:2] ^ g;
      g   = {g[3:0], tks[k]};
      @(negedge clk);
      checks++;
      if (tbl_we !== 1'b1 || tbl_index !== idx || tbl_tag !== pcs[k][31:7] ||
          tbl_target !== tgts[k] || tbl_taken !== tks[k]) begin
        failures++;
        $display("FAIL full_order[%0d]: we=%b idx=%0h tag=%0h tgt=%0h tk=%b required 1 %0h %0h %0h %b",
                 k, tbl_we, tbl_index, tbl_tag, tbl_target, tbl_taken, idx, pcs[k][31:7], tgts[k], tks[k]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0) begin
      failures++;
      $display("FAIL full_drained: we=%b required 0", tbl_we);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [31:0] tgts[3];
    tbl_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tgts[k]          = $urandom;
      res_valid        = 1'b1;
      res_pc           = $urandom;
      res_actual_pc    = tgts[k];
      res_predicted_pc = tgts[k];
      res_taken        = 1'($urandom);
      tick();
    end
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tbl_ready = 1'b1;
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      checks++;
      if (c < 3) begin
        if (tbl_we !== 1'b1 || tbl_clear !== 1'b0 || tbl_target !== tgts[c] || init_done !== 1'b0) begin
          failures++;
          $display("FAIL drain_write[%0d]: we=%b clr=%b tgt=%0h done=%b required 1 0 %0h 0",
                   c, tbl_we, tbl_clear, tbl_target, init_done, tgts[c]);
        end
      end else if (c == 3) begin
        if (tbl_we !== 1'b0 || init_done !== 1'b0) begin
          failures++;
          $display("FAIL drain_empty: we=%b done=%b required 0 0", tbl_we, init_done);
        end
      end else if (c < 36) begin
        if (tbl_we !== 1'b1 || tbl_clear !== 1'b1 || tbl_index !== 5'(c - 4) ||
            init_done !== 1'b0 || ghr !== 5'd0) begin
          failures++;
          $display("FAIL clear_sweep[%0d]: we=%b clr=%b idx=%0d done=%b ghr=%0h required 1 1 %0d 0 0",
                   c, tbl_we, tbl_clear, tbl_index, init_done, ghr, c - 4);
        end
      end else begin
        if (init_done !== 1'b1 || tbl_we !== 1'b0 || ghr !== 5'd0) begin
          failures++;
          $display("FAIL clear_done: done=%b we=%b ghr=%0h required 1 0 0", init_done, tbl_we, ghr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    tbl_ready = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        res_valid        = 1'b1;
        res_pc           = $urandom;
        res_actual_pc    = 32'h0000_0300;
        res_predicted_pc = 32'h0000_0304;
        res_taken        = 1'($urandom);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
          failures++;
          $display("FAIL init_redirect: valid=%b pc=%0h required 1 300", redirect_valid, redirect_pc);
        end
      end
      if (c == 11) begin
        checks++;
        if (tbl_we !== 1'b1 || tbl_index !== 5'd10) begin
          failures++;
          $display("FAIL pre_reset_sweep: we=%b idx=%0d required 1 10", tbl_we, tbl_index);
        end
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (tbl_we !== 1'b0) begin
          failures++;
          $display("FAIL async_reset_we: got %b required 0", tbl_we);
        end
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b1 || tbl_clear !== 1'b1 || tbl_index !== 5'd0 || drop_count !== 8'd0 || ghr !== 5'd0) begin
      failures++;
      $display("FAIL restart_sweep: we=%b clr=%b idx=%0d drops=%0d ghr=%0h required 1 1 0 0 0",
               tbl_we, tbl_clear, tbl_index, drop_count, ghr);
    end
    tick();
  endtask

  task automatic test_random();
    logic       exp_we;
    logic [4:0] exp_idx;
    for (int n = 0; n < 400; n++) begin
      res_valid        = ($urandom_range(0, 9) < 6);
      res_pc           = $urandom;
      res_actual_pc    = $urandom;
      res_predicted_pc = $urandom_range(0, 1) ? res_actual_pc : $urandom;
      res_taken        = 1'($urandom);
      tbl_ready        = ($urandom_range(0, 9) < 6);
      clear_req        = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      exp_we  = (m_phase == 0) || (q.size() > 0);
      exp_idx = (m_phase == 0) ? 5'(m_sweep) : ((q.size() > 0) ? q[0].idx : 5'd0);
      checks++;
      if (res_ready !== (q.size() < DEPTH) || init_done !== (m_phase == 1)) begin
        failures++;
        $display("FAIL rnd_status[%0d]: ready=%b done=%b required %b %b",
                 n, res_ready, init_done, (q.size() < DEPTH), (m_phase == 1));
      end
      checks++;
      if (redirect_valid !== (res_valid && (res_actual_pc != res_predicted_pc)) ||
          redirect_pc !== res_actual_pc) begin
        failures++;
        $display("FAIL rnd_redirect[%0d]: valid=%b pc=%0h", n, redirect_valid, redirect_pc);
      end
      checks++;
      if (tbl_we !== exp_we || (exp_we && (tbl_clear !== (m_phase == 0) || tbl_index !== exp_idx))) begin
        failures++;
        $display("FAIL rnd_write[%0d]: we=%b clr=%b idx=%0h required %b %b %0h",
                 n, tbl_we, tbl_clear, tbl_index, exp_we, (m_phase == 0), exp_idx);
      end
      if (m_phase != 0 && q.size() > 0) begin
        checks++;
        if (tbl_tag !== q[0].tag || tbl_target !== q[0].tgt || tbl_taken !== q[0].tk) begin
          failures++;
          $display("FAIL rnd_head[%0d]: tag=%0h tgt=%0h tk=%b required %0h %0h %b",
                   n, tbl_tag, tbl_target, tbl_taken, q[0].tag, q[0].tgt, q[0].tk);
        end
      end
      checks++;
      if (ghr !== m_ghr || drop_count !== 8'(m_drops)) begin
        failures++;
        $display("FAIL rnd_regs[%0d]: ghr=%0h drops=%0d required %0h %0d", n, ghr, drop_count, m_ghr, m_drops);
      end
      tick();
    end
  endtask

  task automatic test_drop_saturate();
    int budget;
    idle_inputs();
    tbl_ready = 1'b1;
    budget    = 0;
    while (!(m_phase == 1 && q.size() == 0) && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 100) begin
      failures++;
      $display("FAIL sat_settle: phase=%0d occupancy=%0d required 1 0", m_phase, q.size());
    end
    tbl_ready = 1'b0;
    res_valid = 1'b1;
    for (int k = 0; k < 264; k++) begin
      res_pc        = $urandom;
      res_actual_pc = $urandom;
      res_predicted_pc = res_actual_pc;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (drop_count !== 8'd255 || res_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_saturate: drops=%0d ready=%b required 255 0", drop_count, res_ready);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    tbl_ready = 1'b0;
    reset     = 1'b0;
    test_reset();
    test_enqueue();
    test_redirect();
    test_fifo_full();
    test_clear();
    test_reset_mid_init();
    test_random();
    test_drop_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
